ysyx_24100027_ifu: RTL

Instruction fetch unit for the ysyx_24100027 core. It owns the architectural PC register and fetches each instruction from instruction memory over a valid/ready request/response handshake. It presents a stable `pc`/`inst` pair to the single-cycle execute datapath and advances to the `npc` that the datapath returns on commit. It also detects fetch faults, holding the core in a sticky error state, and counts retired instructions.

---
 rtl/ysyx_24100027_ifu.sv | 110 +++++++++++
 1 files changed

// File: rtl/ysyx_24100027_ifu.sv
// Instruction fetch unit: owns the PC, fetches over a valid/ready
// handshake, holds pc/inst for execute, traps fetch faults, counts retires.
module ysyx_24100027_ifu #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   output logic        imem_rsp_ready,
   input  logic [31:0] imem_rsp_data,
   input  logic        imem_rsp_err,
   output logic [31:0] pc,
   output logic [31:0] inst,
   output logic        inst_valid,
   input  logic [31:0] npc,
   input  logic        commit,
   output logic        fetch_err,
   output logic [31:0] err_pc,
   output logic [63:0] instret
);

   typedef enum logic [1:0] {
      S_REQ,
      S_WAIT,
      S_EXEC,
      S_ERR
   } state_e;

   localparam logic [31:0] NOP = 32'h0000_0013;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] err_pc_q, err_pc_d;
   logic [63:0] instret_q, instret_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_REQ;
         pc_q      <= RESET_PC;
         inst_q    <= NOP;
         err_pc_q  <= 32'h0;
         instret_q <= 64'h0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         inst_q    <= inst_d;
         err_pc_q  <= err_pc_d;
         instret_q <= instret_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      inst_d         = inst_q;
      err_pc_d       = err_pc_q;
      instret_d      = instret_q;
      imem_req_valid = 1'b0;
      imem_rsp_ready = 1'b0;
      inst_valid     = 1'b0;
      fetch_err      = 1'b0;
      unique case (state_q)
         S_REQ: begin
            imem_req_valid = 1'b1;
            if (imem_req_ready) state_d = S_WAIT;
         end
         S_WAIT: begin
            imem_rsp_ready = 1'b1;
            if (imem_rsp_valid) begin
               if (imem_rsp_err) begin
                  state_d  = S_ERR;
                  err_pc_d = pc_q;
               end else begin
                  state_d = S_EXEC;
                  inst_d  = imem_rsp_data;
               end
            end
         end
         S_EXEC: begin
            inst_valid = 1'b1;
            if (commit) begin
               // a misaligned target still retires the committing instruction
               instret_d = instret_q + 64'd1;
               if (npc[1:0] == 2'b00) begin
                  pc_d    = npc;
                  state_d = S_REQ;
               end else begin
                  err_pc_d = npc;
                  state_d  = S_ERR;
               end
            end
         end
         S_ERR: begin
            fetch_err = 1'b1;
         end
         default: state_d = S_ERR;
      endcase
   end

   assign imem_req_addr = pc_q;
   assign pc            = pc_q;
   assign inst          = inst_q;
   assign err_pc        = err_pc_q;
   assign instret       = instret_q;

endmodule
